// File: rtl/rbank_pkg.sv
// Shared constants and the state type for the register-bank access controller.
// Register index names follow the processor's G/A register naming.
package rbank_pkg;

  localparam int DATA_W   = 64;
  localparam int SEL_W    = 5;
  localparam int NUM_REGS = 16;

  localparam logic [DATA_W-1:0] REG_RESET_VALUE = 64'h1A1F1A1F1A1F1A1F;

  localparam logic [SEL_W-1:0] G0 = 5'h00;
  localparam logic [SEL_W-1:0] G1 = 5'h01;
  localparam logic [SEL_W-1:0] G2 = 5'h02;
  localparam logic [SEL_W-1:0] G3 = 5'h03;
  localparam logic [SEL_W-1:0] G4 = 5'h04;
  localparam logic [SEL_W-1:0] G5 = 5'h05;
  localparam logic [SEL_W-1:0] G6 = 5'h06;
  localparam logic [SEL_W-1:0] G7 = 5'h07;
  localparam logic [SEL_W-1:0] A0 = 5'h08;
  localparam logic [SEL_W-1:0] A1 = 5'h09;
  localparam logic [SEL_W-1:0] A2 = 5'h0A;
  localparam logic [SEL_W-1:0] A3 = 5'h0B;
  localparam logic [SEL_W-1:0] A4 = 5'h0C;
  localparam logic [SEL_W-1:0] A5 = 5'h0D;
  localparam logic [SEL_W-1:0] A6 = 5'h0E;
  localparam logic [SEL_W-1:0] A7 = 5'h0F;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD_A  = 3'd2,
    S_RD_B  = 3'd3,
    S_CAP_B = 3'd4,
    S_RSP   = 3'd5
  } rbank_ctl_state_t;

endpackage

// File: rtl/rbank_rr_arb2.sv
// Two-way arbiter: req[0] = write, req[1] = read. On a conflict the requester
// that did not win last time is granted; the flag starts with write favoured.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  logic       r_last_wr;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) w_gnt = r_last_wr ? 2'b10 : 2'b01;
      else                w_gnt = i_req;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)       r_last_wr <= 1'b0;
    else if (w_gnt[0]) r_last_wr <= 1'b1;
    else if (w_gnt[1]) r_last_wr <= 1'b0;
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/rbank_ctl.sv
// Access controller for the single-port register bank: arbitrates writeback vs
// operand fetch and sequences the bank's registered-read latency.
module rbank_ctl #(
  parameter int DATA_W   = 64,
  parameter int SEL_W    = 5,
  parameter int NUM_REGS = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [SEL_W-1:0]  i_wr_sel,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_err,
  input  logic              i_rd_valid,
  output logic              o_rd_ready,
  input  logic [SEL_W-1:0]  i_rd_sel_a,
  input  logic [SEL_W-1:0]  i_rd_sel_b,
  input  logic              i_rd_two,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data_a,
  output logic [DATA_W-1:0] o_rsp_data_b,
  output logic              o_rsp_err,
  output logic              o_bank_we,
  output logic [SEL_W-1:0]  o_bank_sel,
  output logic [DATA_W-1:0] o_bank_in,
  input  logic [DATA_W-1:0] i_bank_out
);

  import rbank_pkg::*;

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_WR    = S_WR;
  localparam logic [2:0] ST_RD_A  = S_RD_A;
  localparam logic [2:0] ST_RD_B  = S_RD_B;
  localparam logic [2:0] ST_CAP_B = S_CAP_B;
  localparam logic [2:0] ST_RSP   = S_RSP;

  localparam logic [SEL_W-1:0] SEL_LIMIT = SEL_W'(NUM_REGS);

  logic [2:0]        r_state;
  logic [SEL_W-1:0]  r_wr_sel;
  logic [DATA_W-1:0] r_wr_data;
  logic [SEL_W-1:0]  r_sel_a;
  logic [SEL_W-1:0]  r_sel_b;
  logic              r_two;
  logic [DATA_W-1:0] r_rsp_a;
  logic [DATA_W-1:0] r_rsp_b;
  logic              r_rsp_err;

  logic [1:0] w_gnt;
  logic       w_wr_ok;
  logic       w_rd_bad;

  rr_arb2 u_arb (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_req   ({i_rd_valid, i_wr_valid}),
    .i_en    (r_state == ST_IDLE),
    .o_gnt   (w_gnt)
  );

  assign w_wr_ok  = (r_wr_sel < SEL_LIMIT);
  assign w_rd_bad = (i_rd_sel_a >= SEL_LIMIT) || (i_rd_two && (i_rd_sel_b >= SEL_LIMIT));

  assign o_wr_ready = w_gnt[0];
  assign o_rd_ready = w_gnt[1];

  // A bad read skips the bank entirely and answers with an error next cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_wr_sel  <= '0;
      r_wr_data <= '0;
      r_sel_a   <= '0;
      r_sel_b   <= '0;
      r_two     <= 1'b0;
      r_rsp_a   <= '0;
      r_rsp_b   <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt[0]) begin
            r_wr_sel  <= i_wr_sel;
            r_wr_data <= i_wr_data;
            r_state   <= ST_WR;
          end else if (w_gnt[1]) begin
            r_sel_a <= i_rd_sel_a;
            r_sel_b <= i_rd_sel_b;
            r_two   <= i_rd_two;
            if (w_rd_bad) begin
              r_rsp_a   <= '0;
              r_rsp_b   <= '0;
              r_rsp_err <= 1'b1;
              r_state   <= ST_RSP;
            end else begin
              r_rsp_err <= 1'b0;
              r_state   <= ST_RD_A;
            end
          end
        end
        ST_WR:   r_state <= ST_IDLE;
        ST_RD_A: r_state <= ST_RD_B;
        ST_RD_B: begin
          r_rsp_a <= i_bank_out;
          r_state <= ST_CAP_B;
        end
        ST_CAP_B: begin
          r_rsp_b <= r_two ? i_bank_out : '0;
          r_state <= ST_RSP;
        end
        ST_RSP: begin
          if (i_rsp_ready) begin
            r_rsp_a   <= '0;
            r_rsp_b   <= '0;
            r_rsp_err <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Bank sees idle (zero) drive except in the write and address-issue states.
  always_comb begin
    o_bank_we  = 1'b0;
    o_bank_sel = '0;
    o_bank_in  = '0;
    case (r_state)
      ST_WR: begin
        o_bank_we  = w_wr_ok;
        o_bank_sel = r_wr_sel;
        o_bank_in  = r_wr_data;
      end
      ST_RD_A: o_bank_sel = r_sel_a;
      ST_RD_B: o_bank_sel = r_two ? r_sel_b : r_sel_a;
      default: ;
    endcase
  end

  assign o_wr_err     = (r_state == ST_WR) && !w_wr_ok;
  assign o_rsp_valid  = (r_state == ST_RSP);
  assign o_rsp_data_a = r_rsp_a;
  assign o_rsp_data_b = r_rsp_b;
  assign o_rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_rbank_ctl.sv
// Bench for rbank_ctl: a behavioural bank fixture plus a transaction-level
// reference model that predicts grants, bank writes and read responses.
module tb_rbank_ctl;

  import rbank_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wrValid = 1'b0;
  logic        wrReady;
  logic [4:0]  wrSel = '0;
  logic [63:0] wrData = '0;
  logic        wrErr;
  logic        rdValid = 1'b0;
  logic        rdReady;
  logic [4:0]  rdSelA = '0;
  logic [4:0]  rdSelB = '0;
  logic        rdTwo = 1'b0;
  logic        rspValid;
  logic        rspReady = 1'b0;
  logic [63:0] rspDataA;
  logic [63:0] rspDataB;
  logic        rspErr;
  logic        bankWe;
  logic [4:0]  bankSel;
  logic [63:0] bankIn;
  logic [63:0] bankOut;

  int checkCount = 0;
  int errorCount = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  rbank_ctl dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_wr_valid   (wrValid),
    .o_wr_ready   (wrReady),
    .i_wr_sel     (wrSel),
    .i_wr_data    (wrData),
    .o_wr_err     (wrErr),
    .i_rd_valid   (rdValid),
    .o_rd_ready   (rdReady),
    .i_rd_sel_a   (rdSelA),
    .i_rd_sel_b   (rdSelB),
    .i_rd_two     (rdTwo),
    .o_rsp_valid  (rspValid),
    .i_rsp_ready  (rspReady),
    .o_rsp_data_a (rspDataA),
    .o_rsp_data_b (rspDataB),
    .o_rsp_err    (rspErr),
    .o_bank_we    (bankWe),
    .o_bank_sel   (bankSel),
    .o_bank_in    (bankIn),
    .i_bank_out   (bankOut)
  );

  // Single-port bank: write when we=1, otherwise registered read of sel.
  logic [63:0] bankMem [16];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) bankMem[i] <= REG_RESET_VALUE;
      bankOut <= '0;
    end else if (bankWe) begin
      if (bankSel < 5'd16) bankMem[bankSel[3:0]] <= bankIn;
    end else begin
      bankOut <= (bankSel < 5'd16) ? bankMem[bankSel[3:0]] : 64'd0;
    end
  end

  logic [63:0] refMem [16];
  bit          lastWr;
  int          idleFrom;
  int          wrCycle;
  bit          wrOk;
  logic [4:0]  expWrSel;
  logic [63:0] expWrData;
  bit          rspPending;
  int          rspFrom;
  logic [63:0] expA;
  logic [63:0] expB;
  bit          expErr;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, observed, expected);
    end
  endtask

  function automatic bit selOk(input logic [4:0] s);
    return s < 5'd16;
  endfunction

  // One clock cycle: check outputs, drive inputs, check readies, advance model.
  task automatic applyStimulus(input bit wv, input logic [4:0] ws, input logic [63:0] wd,
                               input bit rv, input logic [4:0] sa, input logic [4:0] sb,
                               input bit two, input bit rr);
    bit rspExp, idle, gW, gR, bad;
    rspExp = rspPending && (cyc >= rspFrom);
    checkOutput("rsp_valid", {63'd0, rspValid}, {63'd0, rspExp});
    if (rspExp) begin
      checkOutput("rsp_data_a", rspDataA, expA);
      checkOutput("rsp_data_b", rspDataB, expB);
      checkOutput("rsp_err", {63'd0, rspErr}, {63'd0, expErr});
    end
    checkOutput("bank_we", {63'd0, bankWe}, {63'd0, (cyc == wrCycle) && wrOk});
    checkOutput("wr_err", {63'd0, wrErr}, {63'd0, (cyc == wrCycle) && !wrOk});
    if (cyc == wrCycle && wrOk) begin
      checkOutput("bank_sel", {59'd0, bankSel}, {59'd0, expWrSel});
      checkOutput("bank_in", bankIn, expWrData);
    end
    wrValid = wv; wrSel = ws; wrData = wd;
    rdValid = rv; rdSelA = sa; rdSelB = sb; rdTwo = two;
    rspReady = rr;
    #1;
    idle = !rspPending && (cyc >= idleFrom);
    gW = idle && wv && (!rv || !lastWr);
    gR = idle && rv && (!wv || lastWr);
    checkOutput("wr_ready", {63'd0, wrReady}, {63'd0, gW});
    checkOutput("rd_ready", {63'd0, rdReady}, {63'd0, gR});
    if (gW) begin
      wrCycle = cyc + 1;
      wrOk = selOk(ws);
      expWrSel = ws;
      expWrData = wd;
      if (wrOk) refMem[ws[3:0]] = wd;
      idleFrom = cyc + 2;
      lastWr = 1'b1;
    end
    if (gR) begin
      bad = !selOk(sa) || (two && !selOk(sb));
      expErr = bad;
      expA = bad ? 64'd0 : refMem[sa[3:0]];
      expB = (bad || !two) ? 64'd0 : refMem[sb[3:0]];
      rspPending = 1'b1;
      rspFrom = cyc + (bad ? 1 : 4);
      lastWr = 1'b0;
    end
    if (rspExp && rr) begin
      rspPending = 1'b0;
      idleFrom = cyc + 1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idleCycle(input bit rr);
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 1'b0, rr);
  endtask

  task automatic doReset();
    reset = 1'b1;
    wrValid = 1'b0; rdValid = 1'b0; rspReady = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) refMem[i] = REG_RESET_VALUE;
    lastWr = 1'b0; idleFrom = cyc; wrCycle = -1; rspPending = 1'b0;
    #1;
    checkOutput("reset_rsp_valid", {63'd0, rspValid}, 64'd0);
    checkOutput("reset_rsp_data_a", rspDataA, 64'd0);
    checkOutput("reset_rsp_data_b", rspDataB, 64'd0);
    checkOutput("reset_rsp_err", {63'd0, rspErr}, 64'd0);
    checkOutput("reset_bank_we", {63'd0, bankWe}, 64'd0);
    checkOutput("reset_bank_sel", {59'd0, bankSel}, 64'd0);
    checkOutput("reset_bank_in", bankIn, 64'd0);
    checkOutput("reset_readies", {62'd0, wrReady, rdReady}, 64'd0);
  endtask

  function automatic logic [4:0] randSel();
    if ($urandom_range(0, 7) == 0) return 5'(16 + $urandom_range(0, 15));
    return 5'($urandom_range(0, 15));
  endfunction

  initial begin
    @(negedge clk);
    doReset();

    // Two-operand read of reset values.
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, G0, A0, 1'b1, 1'b0);
    idleCycle(1'b0); idleCycle(1'b0); idleCycle(1'b0);
    checkOutput("tp_reset_rsp_valid", {63'd0, rspValid}, 64'd1);
    checkOutput("tp_reset_data_a", rspDataA, 64'h1A1F1A1F1A1F1A1F);
    checkOutput("tp_reset_data_b", rspDataB, 64'h1A1F1A1F1A1F1A1F);
    idleCycle(1'b1);

    // Write then read-after-write, single operand.
    applyStimulus(1'b1, G3, 64'hDEADBEEF00000001, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    idleCycle(1'b0);
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, G3, A7, 1'b0, 1'b0);
    idleCycle(1'b0); idleCycle(1'b0); idleCycle(1'b0);
    checkOutput("tp_raw_data_a", rspDataA, 64'hDEADBEEF00000001);
    checkOutput("tp_raw_data_b", rspDataB, 64'd0);
    idleCycle(1'b1);

    // Both requesters always valid from reset: grants must alternate.
    doReset();
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 5'(i % 16), {$urandom, $urandom}, 1'b1, 5'(i % 16), 5'((i + 5) % 16), i[0], 1'b1);
    wrValid = 1'b0; rdValid = 1'b0;
    for (int i = 0; i < 6; i++) idleCycle(1'b1);

    // Invalid write selector, then invalid second operand.
    applyStimulus(1'b1, 5'h12, 64'h0123456789ABCDEF, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    idleCycle(1'b0);
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, G1, 5'h1F, 1'b1, 1'b0);
    checkOutput("tp_bad_rd_err", {63'd0, rspErr}, 64'd1);
    checkOutput("tp_bad_rd_data", rspDataA | rspDataB, 64'd0);
    idleCycle(1'b1);

    // Response back-pressure with a write waiting.
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, G5, A1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, G6, 64'h5555AAAA5555AAAA, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, G6, 64'h5555AAAA5555AAAA, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, G6, 64'h5555AAAA5555AAAA, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    idleCycle(1'b0);

    // Reset while in the second read state, then a fresh read.
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, G6, A2, 1'b1, 1'b1);
    idleCycle(1'b1);
    doReset();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, G6, A2, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) idleCycle(1'b1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 1)), randSel(), {$urandom, $urandom},
                    1'($urandom_range(0, 1)), randSel(), randSel(), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 12; i++) idleCycle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
